// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types for the OTTER memory arbiter: FSM state, grant owner and the
// memory command bundle driven onto the single-ported memory.
package otter_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int MAX_MEM_LAT = 4;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } mem_cmd_t;

  // Instruction fetches are always full-word, unsigned reads.
  function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
    mem_cmd_t c;
    c       = '0;
    c.en    = 1'b1;
    c.addr  = addr;
    c.size  = 2'b10;
    return c;
  endfunction

  function automatic mem_cmd_t data_cmd(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [1:0]  size,
                                        input logic        sign);
    mem_cmd_t c;
    c.en    = 1'b1;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    c.size  = size;
    c.sign  = sign;
    return c;
  endfunction

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Command/response bus between the arbiter and the single-ported,
// synchronous-read memory. The arbiter is the master.
interface otter_mem_arbiter_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] rdata;

  modport master (
    output en, we, addr, wdata, size, sign,
    input  rdata
  );

  modport slave (
    input  en, we, addr, wdata, size, sign,
    output rdata
  );
endinterface

// File: rtl/otter_mem_arbiter_starve.sv
// Starvation counter: counts data grants that beat a waiting fetch and
// raises force_fetch once STARVE_MAX such grants have happened in a row.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic data_contested,
  input  logic fetch_grant,
  output logic force_fetch
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (fetch_grant) begin
      count <= 4'd0;
    end else if (data_contested && (count != LIMIT)) begin
      count <= count + 4'd1;
    end
  end

  assign force_fetch = (count == LIMIT);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Fetch/data arbiter for one single-ported synchronous-read memory.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IF_REQ,
  input  logic [31:0]         IF_ADDR,
  output logic [31:0]         IF_RDATA,
  output logic                IF_VALID,
  output logic                STALL_IF,
  input  logic                D_RE,
  input  logic                D_WE,
  input  logic [31:0]         D_ADDR,
  input  logic [31:0]         D_WDATA,
  input  logic [1:0]          D_SIZE,
  input  logic                D_SIGN,
  output logic [31:0]         D_RDATA,
  output logic                D_VALID,
  output logic                STALL_MEM,
  otter_mem_arbiter_if.master m,
  output arb_state_t          dbg_state
);

  // Handshake: a requester raises its request and holds it until its VALID
  // pulse; VALID is a single-cycle pulse exactly MEM_LAT cycles after the
  // grant, and the request is not eligible again during that pulse cycle.
  localparam int         LAT_CLAMP = (MEM_LAT > MAX_MEM_LAT) ? MAX_MEM_LAT :
                                     (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam logic [2:0] LAT       = 3'(LAT_CLAMP);

  arb_state_t state, next_state;
  arb_owner_t owner, next_owner;
  logic [2:0] cnt, next_cnt;

  logic     resp;
  logic     issue;
  logic     d_req;
  logic     if_elig;
  logic     d_elig;
  logic     force_fetch;
  logic     grant_d;
  logic     grant_if;
  mem_cmd_t cmd;

  assign resp    = (state == ARB_WAIT) && (cnt == 3'd1);
  assign issue   = (state == ARB_IDLE) || resp;
  assign d_req   = D_RE | D_WE;
  assign if_elig = IF_REQ && !(resp && (owner == OWN_IF));
  assign d_elig  = d_req  && !(resp && (owner == OWN_D));

  assign grant_d  = !RESET && issue && d_elig && !(if_elig && force_fetch);
  assign grant_if = !RESET && issue && if_elig && !grant_d;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk            (CLK),
    .rst            (RESET),
    .data_contested (grant_d && if_elig),
    .fetch_grant    (grant_if),
    .force_fetch    (force_fetch)
  );
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ARB_IDLE;
      owner <= OWN_IF;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_owner = owner;
    next_cnt   = cnt;
    cmd        = '0;
    IF_VALID   = 1'b0;
    D_VALID    = 1'b0;
    IF_RDATA   = 32'd0;
    D_RDATA    = 32'd0;

    if (grant_d) begin
      cmd = data_cmd(D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN);
    end else if (grant_if) begin
      cmd = fetch_cmd(IF_ADDR);
    end

    // Response pulse; RESET suppresses it so an in-flight access is dropped.
    if (!RESET && resp) begin
      if (owner == OWN_IF) begin
        IF_VALID = 1'b1;
        IF_RDATA = m.rdata;
      end else begin
        D_VALID  = 1'b1;
        D_RDATA  = m.rdata;
      end
    end

    if (grant_d || grant_if) begin
      next_state = ARB_WAIT;
      next_owner = grant_d ? OWN_D : OWN_IF;
      next_cnt   = LAT;
    end else if (state == ARB_WAIT) begin
      if (cnt > 3'd1) begin
        next_cnt   = cnt - 3'd1;
      end else begin
        next_state = ARB_IDLE;
        next_cnt   = 3'd0;
      end
    end
  end

  assign m.en    = cmd.en;
  assign m.we    = cmd.we;
  assign m.addr  = cmd.addr;
  assign m.wdata = cmd.wdata;
  assign m.size  = cmd.size;
  assign m.sign  = cmd.sign;

  assign STALL_IF  = !RESET && IF_REQ && !IF_VALID;
  assign STALL_MEM = !RESET && d_req  && !D_VALID;
  assign dbg_state = RESET ? ARB_IDLE : state;

endmodule
